// File: rtl/axi_pkg.sv
// Shared AXI definitions for the line write master: FSM state encoding,
// burst/response codes and the AWSIZE helper.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // AWSIZE encodes bytes per beat as log2.
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_line_write_master_if.sv
// AW/W/B channel bundle between the line write master and the memory
// interconnect.
interface axi_line_write_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/line_beat_serializer.sv
// Holds one cache line and hands it out DATA_W bits at a time, beat 0 first,
// flagging the final beat of the burst.
module line_beat_serializer #(
  parameter int LINE_W = 256,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic              shift,
  input  logic [LINE_W-1:0] line_in,
  output logic [DATA_W-1:0] beat_data,
  output logic              last_beat
);

  localparam int BEATS = LINE_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LINE_W-1:0] shreg_q;
  logic [CNT_W-1:0]  beat_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else if (load) begin
      shreg_q    <= line_in;
      beat_cnt_q <= '0;
    end else if (shift) begin
      shreg_q    <= shreg_q >> DATA_W;
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign beat_data = shreg_q[DATA_W-1:0];
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/axi_line_write_master.sv
// Writes one cache line as a single AXI4 INCR burst, one line in flight.
// Optional watchdog on every wait state: define AXI_WR_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for StartWrite; Completed pulses here
// ADDR    | AWVALID held until AW handshake
// DATA    | streaming beats, WLAST on the final beat
// RESP    | BREADY high, waiting for the write response
module axi_line_write_master
  import axi_pkg::*;
#(
  parameter int LINE_W         = 256,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    StartWrite,
  input  logic [LINE_W-1:0]       LineData,
  input  logic [ADDR_W-1:0]       LineAddr,
  output logic                    Completed,
  output logic                    WrError,
  output logic                    Busy,
  axi_line_write_master_if.master m_axi
);

  localparam int BEATS   = LINE_W / DATA_W;
  localparam int ALIGN_W = $clog2(LINE_W / 8);
  localparam logic [2:0] AWSIZE_C = axi_size(DATA_W);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              completed_q;
  logic              wr_error_q;

  logic              load;
  logic              shift;
  logic              b_done;
  logic              to_fire;
  logic              handshake;
  logic              timeout;
  logic [DATA_W-1:0] beat_data;
  logic              last_beat;

  line_beat_serializer #(
    .LINE_W (LINE_W),
    .DATA_W (DATA_W)
  ) u_ser (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (load),
    .shift     (shift),
    .line_in   (LineData),
    .beat_data (beat_data),
    .last_beat (last_beat)
  );

  // A handshake in the same cycle as the watchdog expiry wins: the transfer
  // has already happened on the bus.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    b_done    = 1'b0;
    to_fire   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (StartWrite) begin
          load    = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi.AWREADY) begin
          handshake = 1'b1;
          state_d   = ST_DATA;
        end else if (timeout) begin
          to_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (m_axi.WREADY) begin
          handshake = 1'b1;
          shift     = 1'b1;
          if (last_beat) state_d = ST_RESP;
        end else if (timeout) begin
          to_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (m_axi.BVALID) begin
          handshake = 1'b1;
          b_done    = 1'b1;
          state_d   = ST_IDLE;
        end else if (timeout) begin
          to_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      completed_q <= 1'b0;
      wr_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      completed_q <= b_done | to_fire;
      if (load) begin
        addr_q     <= {LineAddr[ADDR_W-1:ALIGN_W], ALIGN_W'(0)};
        wr_error_q <= 1'b0;
      end else if (b_done) begin
        wr_error_q <= (m_axi.BRESP != AXI_RESP_OKAY);
      end else if (to_fire) begin
        wr_error_q <= 1'b1;
      end
    end
  end

`ifdef AXI_WR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Counts cycles spent waiting in the current state; any handshake restarts it.
  always_ff @(posedge Clk) begin
    if (Reset || state_q == ST_IDLE || handshake) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES ^ handshake;
  assign timeout        = 1'b0;
`endif

  assign Completed = completed_q;
  assign WrError   = wr_error_q;
  assign Busy      = (state_q != ST_IDLE);

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWLEN   = 8'(BEATS - 1);
  assign m_axi.AWSIZE  = AWSIZE_C;
  assign m_axi.AWBURST = AXI_BURST_INCR;
  assign m_axi.AWVALID = (state_q == ST_ADDR);
  assign m_axi.WDATA   = beat_data;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WLAST   = (state_q == ST_DATA) && last_beat;
  assign m_axi.WVALID  = (state_q == ST_DATA);
  assign m_axi.BREADY  = (state_q == ST_RESP);

endmodule

// File: tb/tb_axi_line_write_master.sv
// Directed self-checking bench for axi_line_write_master; the timeout scenario
// runs only when AXI_WR_TIMEOUT_EN is defined (TIMEOUT_CYCLES forced to 16).
module tb_axi_line_write_master;
  import axi_pkg::*;

  logic         Clk;
  logic         Reset;
  logic         StartWrite;
  logic [255:0] LineData;
  logic [31:0]  LineAddr;
  logic         Completed;
  logic         WrError;
  logic         Busy;

  int total = 0;
  int bad   = 0;

  axi_line_write_master_if #(.ADDR_W(32), .DATA_W(32)) m ();

  axi_line_write_master #(
    .LINE_W(256), .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .StartWrite (StartWrite),
    .LineData   (LineData),
    .LineAddr   (LineAddr),
    .Completed  (Completed),
    .WrError    (WrError),
    .Busy       (Busy),
    .m_axi      (m)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // observations from the most recent burst
  int          aw_hs, aw_first, w_early, b_cyc, bready_first;
  int          comp_cnt, comp_cyc, nbeats, timed_out;
  logic        comp_err, comp_busy, comp_bready, err_after;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  w_strb;
  logic [31:0] beat_q[$];
  logic        last_q[$];
  logic [31:0] stall_data_q[$];
  logic        stall_last_q[$];

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + step * i;
    return l;
  endfunction

  // Acts as the slave for one line; records what it sees, checks nothing.
  task automatic do_burst(input logic [31:0] addr, input logic [255:0] line,
                          input int stall_beat, input int stall_len,
                          input logic [1:0] bresp, input logic bvalid_en,
                          input int poke_beat);
    int cyc, stall_left;
    aw_hs = 0; aw_first = -1; w_early = 0; b_cyc = -1; bready_first = -1;
    comp_cnt = 0; comp_cyc = -1; nbeats = 0; timed_out = 0;
    comp_err = 1'b0; comp_busy = 1'b0; comp_bready = 1'b0; err_after = 1'b0;
    beat_q.delete(); last_q.delete(); stall_data_q.delete(); stall_last_q.delete();
    LineAddr = addr; LineData = line; StartWrite = 1'b1;
    m.AWREADY = 1'b1; m.WREADY = 1'b1; m.BVALID = 1'b0; m.BRESP = 2'b00;
    @(negedge Clk);
    LineData = ~line;
    LineAddr = ~addr;
    stall_left = stall_len;
    cyc = 0;
    while (1) begin
      m.WREADY   = !(stall_left > 0 && nbeats == stall_beat);
      StartWrite = (poke_beat >= 0 && nbeats == poke_beat && m.WVALID);
      m.BVALID   = bvalid_en && m.BREADY;
      m.BRESP    = bresp;
      if (m.AWVALID && aw_first < 0) aw_first = cyc;
      if (m.AWVALID && m.AWREADY) begin
        aw_hs++; aw_addr = m.AWADDR; aw_len = m.AWLEN; aw_size = m.AWSIZE; aw_burst = m.AWBURST;
      end
      if (m.WVALID && aw_hs == 0) w_early++;
      if (m.WVALID && !m.WREADY) begin
        stall_data_q.push_back(m.WDATA); stall_last_q.push_back(m.WLAST); stall_left--;
      end
      if (m.WVALID && m.WREADY) begin
        beat_q.push_back(m.WDATA); last_q.push_back(m.WLAST); w_strb = m.WSTRB; nbeats++;
      end
      if (m.BREADY && bready_first < 0) bready_first = cyc;
      if (m.BREADY && m.BVALID) b_cyc = cyc;
      if (Completed) begin
        comp_cnt++;
        if (comp_cyc < 0) begin
          comp_cyc = cyc; comp_err = WrError; comp_busy = Busy; comp_bready = m.BREADY;
        end
      end
      if (comp_cyc >= 0 && cyc >= comp_cyc + 2) begin
        err_after = WrError;
        break;
      end
      if (cyc >= 200) begin
        timed_out = 1;
        break;
      end
      @(negedge Clk);
      cyc++;
    end
    StartWrite = 1'b0; m.BVALID = 1'b0; m.BRESP = 2'b00; m.WREADY = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; StartWrite = 1'b0; LineData = '0; LineAddr = '0;
    m.AWREADY = 1'b0; m.WREADY = 1'b0; m.BVALID = 1'b0; m.BRESP = 2'b00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if ({m.AWVALID, m.WVALID, m.BREADY} !== 3'b000) begin
      bad++; $display("FAIL reset_valids got=%b want=000", {m.AWVALID, m.WVALID, m.BREADY});
    end
    total++;
    if ({Completed, WrError, Busy} !== 3'b000) begin
      bad++; $display("FAIL reset_status got=%b want=000", {Completed, WrError, Busy});
    end
  endtask

  task automatic test_basic();
    logic [255:0] line;
    line = make_line(32'h0, 32'h1111_1111);
    do_burst(32'h1000_0014, line, -1, 0, AXI_RESP_OKAY, 1'b1, -1);
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL basic_budget got=expired want=done"); end
    total++;
    if (aw_hs !== 1 || aw_first !== 0) begin
      bad++; $display("FAIL basic_aw got=hs%0d first%0d want=hs1 first0", aw_hs, aw_first);
    end
    total++;
    if (aw_addr !== 32'h1000_0000) begin bad++; $display("FAIL basic_awaddr got=%h want=10000000", aw_addr); end
    total++;
    if ({aw_len, aw_size, aw_burst} !== {8'd7, 3'd2, 2'b01}) begin
      bad++; $display("FAIL basic_awattr got=len%0d size%0d burst%0d want=len7 size2 burst1", aw_len, aw_size, aw_burst);
    end
    total++;
    if (w_strb !== 4'hF) begin bad++; $display("FAIL basic_wstrb got=%h want=f", w_strb); end
    total++;
    if (beat_q.size() != 8 || w_early != 0) begin
      bad++; $display("FAIL basic_beats got=%0d early%0d want=8 early0", beat_q.size(), w_early);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (beat_q[i] !== 32'h1111_1111 * i || last_q[i] !== (i == 7)) begin
          bad++; $display("FAIL basic_beat%0d got=%h last%b want=%h last%b", i, beat_q[i], last_q[i], 32'h1111_1111 * i, i == 7);
        end
      end
    end
    total++;
    if (b_cyc !== 9 || comp_cyc !== 10) begin
      bad++; $display("FAIL basic_latency got=b%0d comp%0d want=b9 comp10", b_cyc, comp_cyc);
    end
    total++;
    if (comp_cnt !== 1 || comp_err !== 1'b0 || comp_busy !== 1'b0) begin
      bad++; $display("FAIL basic_completed got=cnt%0d err%b busy%b want=cnt1 err0 busy0", comp_cnt, comp_err, comp_busy);
    end
  endtask

  task automatic test_wready_stall();
    logic [255:0] line;
    line = make_line(32'hA500_0000, 32'h0001_0003);
    do_burst(32'h2000_0040, line, 4, 3, AXI_RESP_OKAY, 1'b1, -1);
    total++;
    if (stall_data_q.size() != 3) begin
      bad++; $display("FAIL stall_cycles got=%0d want=3", stall_data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (stall_data_q[i] !== 32'hA504_000C || stall_last_q[i] !== 1'b0) begin
          bad++; $display("FAIL stall_hold%0d got=%h last%b want=a504000c last0", i, stall_data_q[i], stall_last_q[i]);
        end
      end
    end
    total++;
    if (beat_q.size() != 8) begin
      bad++; $display("FAIL stall_beats got=%0d want=8", beat_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (beat_q[i] !== 32'hA500_0000 + 32'h0001_0003 * i || last_q[i] !== (i == 7)) begin
          bad++; $display("FAIL stall_beat%0d got=%h last%b", i, beat_q[i], last_q[i]);
        end
      end
    end
    total++;
    if (b_cyc !== 12 || comp_cyc !== 13 || comp_cnt !== 1) begin
      bad++; $display("FAIL stall_latency got=b%0d comp%0d cnt%0d want=b12 comp13 cnt1", b_cyc, comp_cyc, comp_cnt);
    end
  endtask

  task automatic test_bresp_error();
    do_burst(32'h3000_0000, make_line(32'h5, 32'h7), -1, 0, AXI_RESP_SLVERR, 1'b1, -1);
    total++;
    if (comp_cnt !== 1 || comp_err !== 1'b1) begin
      bad++; $display("FAIL slverr_completed got=cnt%0d err%b want=cnt1 err1", comp_cnt, comp_err);
    end
    total++;
    if (err_after !== 1'b1) begin bad++; $display("FAIL slverr_held got=%b want=1", err_after); end
    do_burst(32'h3000_0020, make_line(32'h9, 32'h3), -1, 0, AXI_RESP_OKAY, 1'b1, -1);
    total++;
    if (comp_cnt !== 1 || comp_err !== 1'b0) begin
      bad++; $display("FAIL okay_after_err got=cnt%0d err%b want=cnt1 err0", comp_cnt, comp_err);
    end
  endtask

  task automatic test_start_while_busy();
    int extra_aw;
    do_burst(32'h4000_0060, make_line(32'hC0DE_0000, 32'h10), -1, 0, AXI_RESP_OKAY, 1'b1, 2);
    total++;
    if (aw_hs !== 1 || beat_q.size() != 8 || comp_cnt !== 1) begin
      bad++; $display("FAIL busy_start got=aw%0d beats%0d comp%0d want=aw1 beats8 comp1", aw_hs, beat_q.size(), comp_cnt);
    end
    extra_aw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (m.AWVALID || Busy) extra_aw++;
    end
    total++;
    if (extra_aw !== 0) begin bad++; $display("FAIL busy_no_queue got=%0d want=0", extra_aw); end
  endtask

  task automatic test_reset_mid_burst();
    int n, cyc;
    logic [255:0] line;
    line = make_line(32'hBEEF_0000, 32'h101);
    LineAddr = 32'h5000_0000; LineData = line; StartWrite = 1'b1;
    m.AWREADY = 1'b1; m.WREADY = 1'b1; m.BVALID = 1'b0;
    @(negedge Clk);
    StartWrite = 1'b0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 50) begin
      if (m.WVALID && m.WREADY) n++;
      @(negedge Clk);
      cyc++;
    end
    total++;
    if (m.WVALID !== 1'b1 || m.WDATA !== 32'hBEEF_0303) begin
      bad++; $display("FAIL midrst_beat3 got=v%b %h want=v1 beef0303", m.WVALID, m.WDATA);
    end
    Reset = 1'b1;
    @(negedge Clk);
    total++;
    if ({m.AWVALID, m.WVALID, m.BREADY, Busy, Completed} !== 5'b0) begin
      bad++; $display("FAIL midrst_abort got=%b want=00000", {m.AWVALID, m.WVALID, m.BREADY, Busy, Completed});
    end
    Reset = 1'b0;
    @(negedge Clk);
    do_burst(32'h5000_0100, make_line(32'h0F0F_0000, 32'h11), -1, 0, AXI_RESP_OKAY, 1'b1, -1);
    total++;
    if (aw_hs !== 1 || beat_q.size() != 8 || comp_cnt !== 1 || comp_err !== 1'b0) begin
      bad++; $display("FAIL midrst_clean got=aw%0d beats%0d comp%0d err%b want=aw1 beats8 comp1 err0",
                      aw_hs, beat_q.size(), comp_cnt, comp_err);
    end else begin
      total++;
      if (beat_q[0] !== 32'h0F0F_0000 || beat_q[7] !== 32'h0F0F_0077 || last_q[7] !== 1'b1) begin
        bad++; $display("FAIL midrst_data got=%h %h last%b want=0f0f0000 0f0f0077 last1", beat_q[0], beat_q[7], last_q[7]);
      end
    end
  endtask

`ifdef AXI_WR_TIMEOUT_EN
  task automatic test_timeout();
    do_burst(32'h6000_0000, make_line(32'h1, 32'h1), -1, 0, AXI_RESP_OKAY, 1'b0, -1);
    total++;
    if (bready_first !== 9 || comp_cyc !== 25) begin
      bad++; $display("FAIL timeout_latency got=resp%0d comp%0d want=resp9 comp25", bready_first, comp_cyc);
    end
    total++;
    if (comp_cnt !== 1 || comp_err !== 1'b1 || comp_busy !== 1'b0 || comp_bready !== 1'b0) begin
      bad++; $display("FAIL timeout_status got=cnt%0d err%b busy%b bready%b want=cnt1 err1 busy0 bready0",
                      comp_cnt, comp_err, comp_busy, comp_bready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wready_stall();
    test_bresp_error();
    test_start_while_busy();
    test_reset_mid_burst();
`ifdef AXI_WR_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
